// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI master.
//   state_e  - master FSM states
//   CMD_*    - two-bit frame commands
//   FRAME_W  - width of the {cmd, data} frame shifted out on MOSI
package spi_pkg;
    typedef enum logic [2:0] {IDLE, SEL, SHIFT, WAIT, RECV, END} state_e;
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;
    localparam int FRAME_W = 10;
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: parallel-load shift register, shifts toward the MSB.
//   clk, rst_n - clock, synchronous active-low reset
//   load       - load load_val (wins over shift)
//   shift      - shift left by one, ser_in entering at bit 0
//   q          - register contents; q[W-1] is the serial output
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int W = FRAME_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         ser_in,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;

    always_comb q_d = load ? load_val : shift ? {q_q[W-2:0], ser_in} : q_q;

    always_ff @(posedge clk) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/spi_master.sv
// spi_master: command/address/data SPI frame master with read-back.
//   clk, rst_n       - clock, synchronous active-low reset
//   start, cmd,      - frame request (sampled only in IDLE) with its
//   data_in            2-bit command and 8-bit payload
//   busy, done       - frame in flight / one-cycle completion pulse
//   rd_data,rd_valid - byte received by a read-data frame and its pulse
//   SS_n, MOSI, MISO - SPI bus
module spi_master
    import spi_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);
    localparam logic [3:0] SHIFT_LAST = 4'(FRAME_W - 1);
    localparam logic [3:0] WAIT_LAST  = 4'(RD_LATENCY - 1);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               rd_q, rd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ss_n_q, ss_n_d;
    logic               mosi_q, mosi_d;
    logic               rd_valid_q, rd_valid_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic [FRAME_W-1:0] tx_q;
    logic [7:0]         rx_q;
    logic               tx_load, tx_shift, rx_shift;
    logic               unused;

    assign tx_load  = state_q == IDLE && start;
    assign tx_shift = state_q == SEL || state_q == SHIFT;
    assign rx_shift = state_q == RECV;
    assign unused   = ^{tx_q[FRAME_W-2:0], rx_q[7]};

    spi_shift_reg #(.W(FRAME_W)) u_tx (
        .clk(clk), .rst_n(rst_n), .load(tx_load), .load_val({cmd, data_in}),
        .shift(tx_shift), .ser_in(1'b0), .q(tx_q)
    );

    spi_shift_reg #(.W(8)) u_rx (
        .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val(8'h00),
        .shift(rx_shift), .ser_in(MISO), .q(rx_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 4'd1;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = SEL;
                    rd_d    = cmd == CMD_RD_DATA;
                end
            end
            SEL: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: if (cnt_q == SHIFT_LAST) begin
                cnt_d   = '0;
                state_d = !rd_q ? END : (RD_LATENCY == 0) ? RECV : WAIT;
            end
            WAIT: if (cnt_q == WAIT_LAST) begin
                cnt_d   = '0;
                state_d = RECV;
            end
            RECV: if (cnt_q == 4'd7) state_d = END;
            END: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        // Outputs are decoded from the next state so they leave flops
        // aligned with the state they describe.
        busy_d     = state_d != IDLE;
        done_d     = state_d == END;
        ss_n_d     = state_d == IDLE || state_d == END;
        // SEL repeats cmd[1]; the TX register starts shifting in SEL so its
        // MSB already holds the next frame bit each SHIFT cycle.
        mosi_d     = state_d == SEL ? cmd[1] : state_d == SHIFT ? tx_q[FRAME_W-1] : 1'b0;
        // Last RECV cycle: fold the final MISO bit in directly so the byte
        // is presented together with done.
        rd_valid_d = state_q == RECV && cnt_q == 4'd7;
        rd_data_d  = rd_valid_d ? {rx_q[6:0], MISO} : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign SS_n     = ss_n_q;
    assign MOSI     = mosi_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: self-checking bench for spi_master (default and zero read latency).
module tb_spi_master;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] data_in = 8'h00;
    logic       MISO = 1'b0;
    logic       use0 = 1'b0;

    logic       start_a, start_b;
    logic       busy_a, done_a, rd_valid_a, ss_n_a, mosi_a;
    logic       busy_b, done_b, rd_valid_b, ss_n_b, mosi_b;
    logic [7:0] rd_data_a, rd_data_b;
    logic       o_busy, o_done, o_rd_valid, o_ss_n, o_mosi;
    logic [7:0] o_rd_data;

    assign start_a    = start & ~use0;
    assign start_b    = start & use0;
    assign o_busy     = use0 ? busy_b : busy_a;
    assign o_done     = use0 ? done_b : done_a;
    assign o_rd_valid = use0 ? rd_valid_b : rd_valid_a;
    assign o_ss_n     = use0 ? ss_n_b : ss_n_a;
    assign o_mosi     = use0 ? mosi_b : mosi_a;
    assign o_rd_data  = use0 ? rd_data_b : rd_data_a;

    spi_master dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .cmd(cmd), .data_in(data_in),
        .busy(busy_a), .done(done_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .SS_n(ss_n_a), .MOSI(mosi_a), .MISO(MISO)
    );

    spi_master #(.RD_LATENCY(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .cmd(cmd), .data_in(data_in),
        .busy(busy_b), .done(done_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .SS_n(ss_n_b), .MOSI(mosi_b), .MISO(MISO)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] rd_cur [2];
    logic [7:0] mem [256];
    logic [7:0] waddr, raddr;

    typedef struct {
        logic       sel;
        logic [1:0] cmd;
        logic [7:0] data;
        logic [7:0] miso;
        int         len;
        logic [7:0] rd;
    } vec_t;
    vec_t tbl [7];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic ss, input logic mo, input logic bz,
                                 input logic dn, input logic rv, input logic [7:0] rd);
        chk1({tag, " SS_n"}, o_ss_n, ss);
        chk1({tag, " MOSI"}, o_mosi, mo);
        chk1({tag, " busy"}, o_busy, bz);
        chk1({tag, " done"}, o_done, dn);
        chk1({tag, " rd_valid"}, o_rd_valid, rv);
        chk8({tag, " rd_data"}, o_rd_data, rd);
    endtask

    // One frame from an IDLE cycle through END; expectations come from the
    // frame rules: SS_n low until the last cycle, MOSI = cmd[1] then the 10
    // frame bits, the reply byte on MISO in the 8 cycles before END.
    task automatic run_frame(input logic [1:0] c, input logic [7:0] d, input logic [7:0] mb,
                             input int len, input logic [7:0] rd_new, input bit hold,
                             input bit noise, input int pulse_k);
        logic [9:0] fr;
        logic       e_end, e_rv, e_mosi;
        int         s;
        fr = {c, d};
        s  = int'(use0);
        @(negedge clk);
        check_outputs($sformatf("dut%0d idle", s), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rd_cur[s]);
        start   = 1'b1;
        cmd     = c;
        data_in = d;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (!hold) start = (k == pulse_k) || (noise && $urandom_range(0, 3) == 0);
            if (noise) begin
                cmd     = 2'($urandom);
                data_in = 8'($urandom);
            end
            e_end  = k == len;
            e_rv   = e_end && c == 2'b11;
            e_mosi = k == 1 ? c[1] : k <= 11 ? fr[11-k] : 1'b0;
            if (e_rv) rd_cur[s] = rd_new;
            check_outputs($sformatf("dut%0d cmd%0d T+%0d", s, c, k), e_end, e_mosi, 1'b1, e_end, e_rv, rd_cur[s]);
            MISO = (c == 2'b11 && k >= len - 8 && k < len) ? mb[len-1-k] : (noise ? 1'($urandom) : 1'b0);
        end
        if (!hold) start = 1'b0;
    endtask

    // Abstract slave: an address register per direction over a 256-byte RAM.
    function automatic logic [7:0] slave(input logic [1:0] c, input logic [7:0] d);
        if (c == 2'b00) waddr = d;
        if (c == 2'b01) mem[waddr] = d;
        if (c == 2'b10) raddr = d;
        return mem[raddr];
    endfunction

    task automatic slave_frame(input logic [1:0] c, input logic [7:0] d, input bit noise);
        logic [7:0] mb;
        int         lat;
        mb  = slave(c, d);
        lat = use0 ? 0 : 2;
        run_frame(c, d, mb, c == 2'b11 ? 20 + lat : 12, mb, 1'b0, noise, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int got;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        waddr = 8'h00;
        raddr = 8'h00;
        rd_cur[0] = 8'h00;
        rd_cur[1] = 8'h00;
        tbl[0] = '{1'b0, 2'b00, 8'hA5, 8'h00, 12, 8'h00};
        tbl[1] = '{1'b0, 2'b11, 8'h00, 8'h3C, 22, 8'h3C};
        tbl[2] = '{1'b0, 2'b01, 8'h5A, 8'hFF, 12, 8'h3C};
        tbl[3] = '{1'b0, 2'b10, 8'hFF, 8'h00, 12, 8'h3C};
        tbl[4] = '{1'b1, 2'b11, 8'h81, 8'hA7, 20, 8'hA7};
        tbl[5] = '{1'b1, 2'b00, 8'h01, 8'h00, 12, 8'hA7};
        tbl[6] = '{1'b0, 2'b11, 8'hFF, 8'h96, 22, 8'h96};

        // reset with start held high must stay idle
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs("reset dut0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        use0 = 1'b1;
        #1;
        check_outputs("reset dut1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        use0  = 1'b0;
        start = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            use0 = tbl[i].sel;
            run_frame(tbl[i].cmd, tbl[i].data, tbl[i].miso, tbl[i].len, tbl[i].rd, 1'b0, 1'b0, 0);
        end

        // start pulse mid write frame is ignored
        use0 = 1'b0;
        run_frame(2'b01, 8'h33, 8'h00, 12, rd_cur[0], 1'b0, 1'b0, 5);

        // start held high: back-to-back frames
        run_frame(2'b00, 8'h12, 8'h00, 12, rd_cur[0], 1'b1, 1'b0, 0);
        run_frame(2'b01, 8'h34, 8'h00, 12, rd_cur[0], 1'b1, 1'b0, 0);
        run_frame(2'b11, 8'h56, 8'h6E, 22, 8'h6E, 1'b0, 1'b0, 0);

        // write then read back through the slave
        slave_frame(2'b00, 8'h10, 1'b0);
        slave_frame(2'b01, 8'hC3, 1'b0);
        slave_frame(2'b10, 8'h10, 1'b0);
        slave_frame(2'b11, 8'h00, 1'b0);
        chk8("slave readback", o_rd_data, 8'hC3);

        for (int i = 0; i < 120; i++) begin
            use0 = 1'($urandom);
            slave_frame(2'($urandom), 8'($urandom), 1'b1);
        end

        // reset in the middle of a read frame
        use0 = 1'b0;
        MISO = 1'b1;
        @(negedge clk);
        start   = 1'b1;
        cmd     = 2'b11;
        data_in = 8'h42;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk1("pre-abort busy", o_busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs("abort T+16", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        rd_cur[0] = 8'h00;
        rd_cur[1] = 8'h00;
        start   = 1'b1;
        cmd     = 2'b10;
        data_in = 8'h77;
        repeat (2) begin
            @(negedge clk);
            chk1("start in reset busy", o_busy, 1'b0);
            chk1("start in reset SS_n", o_ss_n, 1'b1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk1("first accept busy", o_busy, 1'b1);
        chk1("first accept SS_n", o_ss_n, 1'b0);
        chk1("first accept MOSI", o_mosi, 1'b1);
        start = 1'b0;
        got = 0;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (o_done) begin
                got = k;
                break;
            end
        end
        chk8("post-reset frame length", 8'(got), 8'd12);
        chk1("post-reset rd_valid", o_rd_valid, 1'b0);
        chk8("post-reset rd_data", o_rd_data, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
